// File: rtl/ltl_monitor_cluster.sv
// Parametrised LTL monitor cluster: per-property violation lanes plus first-violation capture.
// Optional macro LTL_MON_SYMBOL_TRACE_EN builds the first_sym capture register.

module ltl_prop_lane #(
    parameter int NUM_REPORTS = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   en,
    input  logic [NUM_REPORTS-1:0] rep,
    input  logic                   clr,
    output logic                   hit,
    output logic                   live,
    output logic                   sticky,
    output logic [CNT_W-1:0]       count
);
    logic             live_q, live_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        hit      = run & en & (|rep);
        live_d   = hit;
        // A hit in the clear cycle wins over the clear.
        sticky_d = hit ? 1'b1 : (clr ? 1'b0 : sticky_q);
        count_d  = count_q;
        if (clr)
            count_d = hit ? CNT_W'(1) : '0;
        else if (hit && !(&count_q))
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q   <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign live   = live_q;
    assign sticky = sticky_q;
    assign count  = count_q;
endmodule

module ltl_monitor_cluster #(
    parameter int NUM_PROPS   = 10,
    parameter int NUM_REPORTS = 4,
    parameter int SYM_W       = 8,
    parameter int CNT_W       = 16,
    parameter int TS_W        = 32,
    parameter int ID_W        = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             run,
    input  logic [SYM_W-1:0]                 symbols,
    input  logic [NUM_PROPS*NUM_REPORTS-1:0] report_in,
    input  logic [NUM_PROPS-1:0]             prop_en,
    input  logic [NUM_PROPS-1:0]             clear_mask,
    input  logic                             ack,
    output logic [NUM_PROPS-1:0]             viol_live,
    output logic [NUM_PROPS-1:0]             viol_sticky,
    output logic [NUM_PROPS*CNT_W-1:0]       viol_count,
    output logic                             first_valid,
    output logic [ID_W-1:0]                  first_id,
    output logic [TS_W-1:0]                  first_ts,
    output logic [SYM_W-1:0]                 first_sym,
    output logic                             irq
);
    typedef enum logic {ARMED = 1'b0, HELD = 1'b1} state_e;

    logic [NUM_PROPS-1:0] hit;

    for (genvar p = 0; p < NUM_PROPS; p++) begin : g_lane
        ltl_prop_lane #(
            .NUM_REPORTS(NUM_REPORTS),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .run   (run),
            .en    (prop_en[p]),
            .rep   (report_in[p*NUM_REPORTS +: NUM_REPORTS]),
            .clr   (clear_mask[p]),
            .hit   (hit[p]),
            .live  (viol_live[p]),
            .sticky(viol_sticky[p]),
            .count (viol_count[p*CNT_W +: CNT_W])
        );
    end

    state_e          state_q, state_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [ID_W-1:0] first_id_q, first_id_d;
    logic [TS_W-1:0] first_ts_q, first_ts_d;
    logic [ID_W-1:0] low_id;
    logic            any_hit;
    logic            capture;

    always_comb begin
        any_hit = |hit;
        low_id  = '0;
        for (int p = NUM_PROPS - 1; p >= 0; p--)
            if (hit[p]) low_id = ID_W'(p);
        // An ack coinciding with a new hit re-arms and recaptures in one step.
        capture    = any_hit && (state_q == ARMED || ack);
        state_d    = state_q;
        if (any_hit)
            state_d = HELD;
        else if (state_q == HELD && ack)
            state_d = ARMED;
        ts_d       = run ? ts_q + TS_W'(1) : ts_q;
        first_id_d = capture ? low_id : first_id_q;
        first_ts_d = capture ? ts_q : first_ts_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARMED;
            ts_q       <= '0;
            first_id_q <= '0;
            first_ts_q <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            first_id_q <= first_id_d;
            first_ts_q <= first_ts_d;
        end
    end

`ifdef LTL_MON_SYMBOL_TRACE_EN
    logic [SYM_W-1:0] first_sym_q, first_sym_d;

    always_comb first_sym_d = capture ? symbols : first_sym_q;

    always_ff @(posedge clk) begin
        if (reset) first_sym_q <= '0;
        else       first_sym_q <= first_sym_d;
    end

    assign first_sym = first_sym_q;
`else
    logic unused_symbols;
    assign unused_symbols = ^symbols;
    assign first_sym      = '0;
`endif

    assign first_valid = (state_q == HELD);
    assign irq         = first_valid;
    assign first_id    = first_id_q;
    assign first_ts    = first_ts_q;
endmodule
